demux4_buf: RTL and testbench

DEMUX4_BUF -- requirements
Module: demux4_buf

---
 rtl/demux4_buf_pkg.sv | 13 +
 rtl/demux_slot.sv | 52 +++++
 rtl/demux4_buf.sv | 51 +++++
 tb/tb_demux4_buf.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/demux4_buf_pkg.sv
// Shared constants and types for the four-channel buffered demultiplexer.
package demux4_buf_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : demux4_buf_pkg

// File: rtl/demux_slot.sv
// One output channel: a single-entry buffer plus a wrapping count of accepted words.
module demux_slot
  import demux4_buf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rd_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next state: a write always leaves the slot full, a read with no write empties it.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    if (wr_i) begin
      state_d = SLOT_FULL;
      data_d  = data_i;
      count_d = count_q + CNT_W'(1);
    end else if ((state_q == SLOT_FULL) && rd_ready_i) begin
      state_d = SLOT_EMPTY;
    end
  end

  // State, held word and counter registers; reset discards any held word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule : demux_slot

// File: rtl/demux4_buf.sv
// Routes each accepted input word to one of four single-entry channel buffers.
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [WIDTH-1:0]        in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [WIDTH-1:0]        out_data0,
  output logic [WIDTH-1:0]        out_data1,
  output logic [WIDTH-1:0]        out_data2,
  output logic [WIDTH-1:0]        out_data3,
  output logic [NUM_CH*CNT_W-1:0] out_count
);

  logic [NUM_CH-1:0] wrEn;
  logic [WIDTH-1:0]  slotData [NUM_CH];

  // The selected channel can take a word if it is empty or draining this cycle,
  // so a stalled channel never blocks the others.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    assign wrEn[k] = in_valid & in_ready & (in_sel == SEL_W'(k));

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_i      (wrEn[k]),
      .data_i    (in_data),
      .rd_ready_i(out_ready[k]),
      .valid_o   (out_valid[k]),
      .data_o    (slotData[k]),
      .count_o   (out_count[k*CNT_W +: CNT_W])
    );
  end

  assign out_data0 = slotData[0];
  assign out_data1 = slotData[1];
  assign out_data2 = slotData[2];
  assign out_data3 = slotData[3];

endmodule : demux4_buf

// File: tb/tb_demux4_buf.sv
// Self-checking bench for demux4_buf: directed scenarios followed by random stress
// against a per-channel queue model.
module tb_demux4_buf;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_data0, out_data1, out_data2, out_data3;
  logic [31:0] out_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: words waiting in each channel, words accepted per channel,
  // and the last word delivered to each channel.
  logic [7:0] chq [4][$];
  logic [7:0] cnt [4];
  logic [7:0] last [4];

  demux4_buf #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data0(out_data0),
    .out_data1(out_data1),
    .out_data2(out_data2),
    .out_data3(out_data3),
    .out_count(out_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] dataOf(input int k);
    case (k)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [7:0] d,
                               input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic resetModel();
    for (int k = 0; k < 4; k++) begin
      chq[k].delete();
      cnt[k]  = 8'd0;
      last[k] = 8'd0;
    end
  endtask

  // Called between edges with inputs already driven: predicts this cycle's
  // transfers, then crosses one rising edge and checks the resulting state.
  task automatic stepCycle();
    logic       expReady;
    logic [3:0] expValid;
    logic [31:0] expCount;
    expReady = (chq[in_sel].size() == 0) || out_ready[in_sel];
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
    for (int k = 0; k < 4; k++) begin
      if (chq[k].size() != 0 && out_ready[k]) begin
        checkOutput($sformatf("pop_data%0d", k), {24'd0, dataOf(k)}, {24'd0, chq[k][0]});
        void'(chq[k].pop_front());
      end
    end
    if (in_valid && expReady) begin
      chq[in_sel].push_back(in_data);
      cnt[in_sel]  = cnt[in_sel] + 8'd1;
      last[in_sel] = in_data;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      expValid[k] = (chq[k].size() != 0);
      expCount[k*8 +: 8] = cnt[k];
      checkOutput($sformatf("data%0d", k), {24'd0, dataOf(k)}, {24'd0, last[k]});
    end
    checkOutput("out_valid", {28'd0, out_valid}, {28'd0, expValid});
    checkOutput("out_count", out_count, expCount);
  endtask

  initial begin
    logic [7:0] lastWord;
    resetModel();
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0000);
    reset_n = 1'b0;
    #2;
    checkOutput("rst_valid", {28'd0, out_valid}, 32'd0);
    checkOutput("rst_count", out_count, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic routing to channel 2.
    applyStimulus(1'b1, 2'd2, 8'hA5, 4'b0000);
    @(negedge clk);
    stepCycle();
    checkOutput("route_valid", {28'd0, out_valid}, 32'h4);
    checkOutput("route_data2", {24'd0, out_data2}, 32'hA5);
    checkOutput("route_cnt2", {24'd0, out_count[23:16]}, 32'd1);

    // Backpressure: channel 1 full and stalled, channel 3 still accepts.
    applyStimulus(1'b1, 2'd1, 8'h5A, 4'b0000);
    @(negedge clk);
    stepCycle();
    applyStimulus(1'b1, 2'd1, 8'h3C, 4'b0000);
    @(negedge clk);
    checkOutput("bp_ready_blocked", {31'd0, in_ready}, 32'd0);
    stepCycle();
    checkOutput("bp_data1_kept", {24'd0, out_data1}, 32'h5A);
    applyStimulus(1'b1, 2'd3, 8'h3C, 4'b0000);
    @(negedge clk);
    checkOutput("bp_ready_other", {31'd0, in_ready}, 32'd1);
    stepCycle();
    checkOutput("bp_valid", {28'd0, out_valid}, 32'hE);
    checkOutput("bp_data3", {24'd0, out_data3}, 32'h3C);

    // Simultaneous consume and reload on channel 0.
    applyStimulus(1'b1, 2'd0, 8'h11, 4'b0000);
    @(negedge clk);
    stepCycle();
    applyStimulus(1'b1, 2'd0, 8'h22, 4'b0001);
    @(negedge clk);
    checkOutput("sim_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("sim_old_data", {24'd0, out_data0}, 32'h11);
    stepCycle();
    checkOutput("sim_valid0", {31'd0, out_valid[0]}, 32'd1);
    checkOutput("sim_data0", {24'd0, out_data0}, 32'h22);

    // Reset pulsed between edges while channels hold words.
    applyStimulus(1'b1, 2'd0, 8'h77, 4'b0000);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {28'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_count", out_count, 32'd0);
    checkOutput("mid_rst_data0", {24'd0, out_data0}, 32'd0);
    checkOutput("mid_rst_data2", {24'd0, out_data2}, 32'd0);
    checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    resetModel();
    @(posedge clk);
    #1;
    checkOutput("in_rst_valid", {28'd0, out_valid}, 32'd0);
    checkOutput("in_rst_count", out_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0000);
    @(posedge clk);
    #1;

    // Counter wrap: 256 words into channel 3 with every consumer ready.
    lastWord = 8'd0;
    for (int i = 0; i < 256; i++) begin
      lastWord = 8'($urandom);
      applyStimulus(1'b1, 2'd3, lastWord, 4'b1111);
      @(negedge clk);
      stepCycle();
    end
    checkOutput("wrap_cnt3", {24'd0, out_count[31:24]}, 32'd0);
    checkOutput("wrap_data3", {24'd0, out_data3}, {24'd0, lastWord});

    // Random stress against the queue model.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom), 4'($urandom));
      @(negedge clk);
      stepCycle();
    end
    // Drain everything and confirm nothing is left behind.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'($urandom), 8'($urandom), 4'b1111);
      @(negedge clk);
      stepCycle();
    end
    checkOutput("drain_valid", {28'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux4_buf
